// File: rtl/fsm_pkg.sv
// Shared helpers for the parametrised ring controllers: state-width sizing,
// direction encoding and parameter legality.
package fsm_pkg;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_BWD = 1'b1;

   localparam int MIN_STATES = 2;
   localparam int MAX_STATES = 256;

   // Binary state width; never narrower than one bit.
   function automatic int state_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic bit num_states_ok(input int n);
      return (n >= MIN_STATES) && (n <= MAX_STATES);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; clear wins over increment.
module sat_counter #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX = {W{1'b1}};

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && (count_q != MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ring_fsm_param.sv
// NUM_STATES-state ring sequencer with direction control, synchronous jump,
// wrap / illegal-load pulses and a saturating dwell counter.
module ring_fsm_param
   import fsm_pkg::*;
#(
   parameter  int NUM_STATES = 7,
   parameter  int DWELL_W    = 4,
   localparam int SW         = state_w(NUM_STATES)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  en,
   input  logic [NUM_STATES-1:0] cond,
   input  logic                  dir,
   input  logic                  load,
   input  logic [SW-1:0]         load_state,
   output logic [SW-1:0]         y,
   output logic                  wrap,
   output logic                  load_err,
   output logic [DWELL_W-1:0]    dwell
);

   if (!num_states_ok(NUM_STATES)) begin : g_bad_num_states
      $error("ring_fsm_param: NUM_STATES must be in 2..256");
   end

   localparam logic [SW-1:0] LAST  = SW'(NUM_STATES - 1);
   // One extra bit so NUM_STATES itself is representable (e.g. 256 with SW=8).
   localparam logic [SW:0]   N_EXT = (SW + 1)'(NUM_STATES);

   logic [SW-1:0] y_q;
   logic [SW-1:0] y_d;
   logic          wrap_q;
   logic          wrap_d;
   logic          load_err_q;
   logic          load_err_d;

   logic load_legal;
   logic load_bad;
   logic advance;
   logic dwell_clr;
   logic dwell_inc;

   assign load_legal = load && ({1'b0, load_state} < N_EXT);
   assign load_bad   = load && !load_legal;
   assign advance    = !load && en && cond[y_q];

   always_comb begin
      y_d        = y_q;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;
      if (load_legal) begin
         y_d = load_state;
      end else if (load_bad) begin
         load_err_d = 1'b1;
      end else if (advance) begin
         if (dir == DIR_FWD) begin
            y_d    = (y_q == LAST) ? '0 : y_q + 1'b1;
            wrap_d = (y_q == LAST);
         end else begin
            y_d    = (y_q == '0) ? LAST : y_q - 1'b1;
            wrap_d = (y_q == '0);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         y_q        <= '0;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         y_q        <= y_d;
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end
   end

   // Any state entry (legal jump or advance) restarts the dwell count.
   assign dwell_clr = load_legal || advance;
   assign dwell_inc = !dwell_clr;

   sat_counter #(
      .W (DWELL_W)
   ) u_dwell (
      .clock (clock),
      .reset (reset),
      .clear (dwell_clr),
      .inc   (dwell_inc),
      .count (dwell)
   );

   assign y        = y_q;
   assign wrap     = wrap_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_ring_fsm_param.sv
// Directed bench for ring_fsm_param at NUM_STATES = 7, 2 and 16.
module tb_ring_fsm_param;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic en    = 1'b1;

   logic [6:0] cond7  = '1;
   logic       dir7   = 1'b0;
   logic       load7  = 1'b0;
   logic [2:0] ls7    = '0;
   logic [2:0] y7;
   logic       w7;
   logic       e7;
   logic [3:0] d7;

   logic [1:0] cond2  = '1;
   logic       dir2   = 1'b0;
   logic       load2  = 1'b0;
   logic       ls2    = 1'b0;
   logic       y2;
   logic       w2;
   logic       e2;
   logic [3:0] d2;

   logic [15:0] cond16 = '1;
   logic        dir16  = 1'b0;
   logic        load16 = 1'b0;
   logic [3:0]  ls16   = '0;
   logic [3:0]  y16;
   logic        w16;
   logic        e16;
   logic [3:0]  d16;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   ring_fsm_param #(.NUM_STATES(7), .DWELL_W(4)) dut7 (
      .clock(clock), .reset(reset), .en(en), .cond(cond7), .dir(dir7),
      .load(load7), .load_state(ls7), .y(y7), .wrap(w7), .load_err(e7), .dwell(d7)
   );

   ring_fsm_param #(.NUM_STATES(2), .DWELL_W(4)) dut2 (
      .clock(clock), .reset(reset), .en(en), .cond(cond2), .dir(dir2),
      .load(load2), .load_state(ls2), .y(y2), .wrap(w2), .load_err(e2), .dwell(d2)
   );

   ring_fsm_param #(.NUM_STATES(16), .DWELL_W(4)) dut16 (
      .clock(clock), .reset(reset), .en(en), .cond(cond16), .dir(dir16),
      .load(load16), .load_state(ls16), .y(y16), .wrap(w16), .load_err(e16), .dwell(d16)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk7(input string tag, input int ey, input int ew, input int ee, input int ed);
      chk({tag, " y"},        int'(y7), ey);
      chk({tag, " wrap"},     int'(w7), ew);
      chk({tag, " load_err"}, int'(e7), ee);
      chk({tag, " dwell"},    int'(d7), ed);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      // Test 1: forward ring, wrap only on return to 0
      do_reset();
      chk7("t1 reset", 0, 0, 0, 0);
      for (int i = 1; i <= 9; i++) begin
         step();
         chk7("t1 fwd", i % 7, (i == 7) ? 1 : 0, 0, 0);
      end

      // Test 2: stall on cond[3]=0, dwell saturates at 15
      do_reset();
      cond7 = 7'b1110111;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk7("t2 approach", i, 0, 0, 0);
      end
      for (int k = 1; k <= 17; k++) begin
         step();
         chk7("t2 stall", 3, 0, 0, (k > 15) ? 15 : k);
      end
      cond7 = '1;
      step();
      chk7("t2 release", 4, 0, 0, 0);

      // Test 3: backward ring, then reversal at y=4
      dir7 = 1'b1;
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         step();
         chk7("t3 bwd", (14 - i) % 7, (i == 1 || i == 8) ? 1 : 0, 0, 0);
      end
      chk("t3 at4", int'(y7), 4);
      dir7 = 1'b0;
      step();
      chk7("t3 reverse", 5, 0, 0, 0);

      // Test 4: load priority, illegal load, reload of current state
      do_reset();
      step();
      step();
      chk("t4 at2", int'(y7), 2);
      load7 = 1'b1; ls7 = 3'd5;
      step();
      chk7("t4 load5", 5, 0, 0, 0);
      ls7 = 3'd2;
      step();
      chk7("t4 load2", 2, 0, 0, 0);
      ls7 = 3'd7;
      step();
      chk7("t4 illegal", 2, 0, 1, 1);
      load7 = 1'b0; en = 1'b0;
      step();
      chk7("t4 err drop", 2, 0, 0, 2);
      load7 = 1'b1; ls7 = 3'd2;
      step();
      chk7("t4 reload same", 2, 0, 0, 0);
      ls7 = 3'd6;
      step();
      load7 = 1'b0; en = 1'b1;
      step();
      chk7("t4 wrap after load", 0, 1, 0, 0);
      step();
      chk7("t4 wrap single", 1, 0, 0, 0);

      // Test 5: hold with en=0, then reset overrides pending load
      do_reset();
      for (int i = 1; i <= 4; i++) step();
      chk("t5 at4", int'(y7), 4);
      en = 1'b0;
      for (int i = 1; i <= 10; i++) step();
      chk7("t5 hold", 4, 0, 0, 10);
      load7 = 1'b1; ls7 = 3'd7;
      step();
      chk7("t5 illegal", 4, 0, 1, 11);
      ls7 = 3'd3;
      reset = 1'b1;
      step();
      chk7("t5 reset", 0, 0, 0, 0);
      reset = 1'b0; load7 = 1'b0; en = 1'b1;

      // Test 6a: N=2 forward then backward wrap
      do_reset();
      chk("t6 n2 reset", int'(y2), 0);
      step(); chk("t6 n2 f y", int'(y2), 1); chk("t6 n2 f w", int'(w2), 0);
      step(); chk("t6 n2 f y", int'(y2), 0); chk("t6 n2 f w", int'(w2), 1);
      step(); chk("t6 n2 f y", int'(y2), 1); chk("t6 n2 f w", int'(w2), 0);
      dir2 = 1'b1;
      step(); chk("t6 n2 b y", int'(y2), 0); chk("t6 n2 b w", int'(w2), 0);
      step(); chk("t6 n2 b y", int'(y2), 1); chk("t6 n2 b w", int'(w2), 1);

      // Test 6b: N=16 forward/backward wrap, load_err never set
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         step();
         chk("t6 n16 f y", int'(y16), i % 16);
         chk("t6 n16 f w", int'(w16), (i == 16) ? 1 : 0);
         chk("t6 n16 err", int'(e16), 0);
      end
      dir16 = 1'b1;
      step(); chk("t6 n16 b y", int'(y16), 0);  chk("t6 n16 b w", int'(w16), 0);
      step(); chk("t6 n16 b y", int'(y16), 15); chk("t6 n16 b w", int'(w16), 1);
      step(); chk("t6 n16 b y", int'(y16), 14); chk("t6 n16 b w", int'(w16), 0);
      load16 = 1'b1; ls16 = 4'd15;
      step();
      chk("t6 n16 load y", int'(y16), 15);
      chk("t6 n16 load err", int'(e16), 0);
      chk("t6 n16 load dwell", int'(d16), 0);
      load16 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
